// File: rtl/v850_pkg.sv
// Shared types and helpers for the V850 sequencer: state encoding, default
// vectors, and the PC normalisation rule used on every PC load.
package v850_pkg;

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        IRQ    = 3'd5,
        HALT   = 3'd6
    } seq_state_t;

    localparam logic [31:0] V850_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] V850_IRQ_VECTOR = 32'h0000_0080;

    // Program space is 26 bits; upper bits mirror bit 25 and bit 0 is never set.
    function automatic logic [31:0] sext_pc(input logic [31:0] a);
        return {{6{a[25]}}, a[25:1], 1'b0};
    endfunction

endpackage

// File: rtl/v850_pc_reg.sv
// Program counter register: reset / interrupt vector / pending-PC load with
// normalisation applied to whichever value is loaded.
module v850_pc_reg
    import v850_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = V850_RESET_PC,
    parameter logic [31:0] IRQ_VECTOR = V850_IRQ_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_pend,
    input  logic        ld_vec,
    input  logic [31:0] pend_pc,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (rst)
            pc <= sext_pc(RESET_PC);
        else if (ld_vec)
            pc <= sext_pc(IRQ_VECTOR);
        else if (ld_pend)
            pc <= sext_pc(pend_pc);
    end

endmodule

// File: rtl/v850_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> WB, with
// EI-level interrupt entry and HALT. Strobes are decoded from the state register.
module v850_seq_ctrl
    import v850_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = V850_RESET_PC,
    parameter logic [31:0] IRQ_VECTOR = V850_IRQ_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir_o,
    output logic        decode_en,
    output logic        exec_en,
    input  logic        exec_done,
    input  logic [31:0] next_pc_i,
    input  logic        halt_i,
    output logic        wb_en,
    output logic [31:0] pc_o,
    input  logic        irq_req,
    input  logic [15:0] irq_code,
    input  logic        psw_id_i,
    output logic        irq_ack,
    output logic        eipc_we,
    output logic [31:0] eipc_o,
    output logic [31:0] eiic_o,
    output logic [2:0]  state_o
);

    seq_state_t  state, state_nx;
    logic [31:0] pend_pc;
    logic        halt_q;
    logic        ld_pend, ld_vec;
    logic        irq_take;

    assign irq_take = irq_req && !psw_id_i;

    always_ff @(posedge clk) begin
        if (rst)
            state <= RESET;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld_pend  = 1'b0;
        ld_vec   = 1'b0;
        case (state)
            RESET:  state_nx = FETCH;
            FETCH:  if (imem_ack) state_nx = DECODE;
            DECODE: state_nx = EXEC;
            EXEC:   if (exec_done) state_nx = WB;
            WB: begin
                // Interrupt wins over HALT; PC stays put so the return address
                // is still sitting in pend_pc for the IRQ cycle.
                if (irq_take) begin
                    state_nx = IRQ;
                end else begin
                    ld_pend  = 1'b1;
                    state_nx = halt_q ? HALT : FETCH;
                end
            end
            IRQ: begin
                ld_vec   = 1'b1;
                state_nx = FETCH;
            end
            HALT:   if (irq_take) state_nx = IRQ;
            default: state_nx = RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_o    <= 32'h0;
            pend_pc <= 32'h0;
            halt_q  <= 1'b0;
        end else begin
            if (state == FETCH && imem_ack)
                ir_o <= imem_rdata;
            if (state == EXEC && exec_done) begin
                pend_pc <= next_pc_i;
                halt_q  <= halt_i;
            end
            // Waking from HALT returns to the instruction after the HALT.
            if (state == HALT && irq_take)
                pend_pc <= pc_o;
            if (state == IRQ)
                halt_q <= 1'b0;
        end
    end

    v850_pc_reg #(
        .RESET_PC   (RESET_PC),
        .IRQ_VECTOR (IRQ_VECTOR)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .ld_pend (ld_pend),
        .ld_vec  (ld_vec),
        .pend_pc (pend_pc),
        .pc      (pc_o)
    );

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc_o;
    assign decode_en = (state == DECODE);
    assign exec_en   = (state == EXEC);
    assign wb_en     = (state == WB);
    assign irq_ack   = (state == IRQ);
    assign eipc_we   = (state == IRQ);
    assign eipc_o    = (state == IRQ) ? pend_pc : 32'h0;
    assign eiic_o    = (state == IRQ) ? {16'h0, irq_code} : 32'h0;
    assign state_o   = state;

endmodule

// File: tb/tb_v850_seq_ctrl.sv
// Randomized bench for v850_seq_ctrl: a reactive memory/executer model feeds
// the DUT and queues expected fetch/interrupt events; a monitor checks them.
module tb_v850_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] VEC    = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, ir_o;
    logic        decode_en, exec_en, exec_done, halt_i, wb_en;
    logic [31:0] next_pc_i, pc_o;
    logic        irq_req, psw_id_i, irq_ack, eipc_we;
    logic [15:0] irq_code;
    logic [31:0] eipc_o, eiic_o;
    logic [2:0]  state_o;

    v850_seq_ctrl #(.RESET_PC(RST_PC), .IRQ_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir_o(ir_o), .decode_en(decode_en), .exec_en(exec_en), .exec_done(exec_done),
        .next_pc_i(next_pc_i), .halt_i(halt_i), .wb_en(wb_en), .pc_o(pc_o),
        .irq_req(irq_req), .irq_code(irq_code), .psw_id_i(psw_id_i),
        .irq_ack(irq_ack), .eipc_we(eipc_we), .eipc_o(eipc_o), .eiic_o(eiic_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_irq;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t exq[$];
    ev_t ev;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Architectural PC rule: 26-bit space sign-extended from bit 25, halfword aligned.
    function automatic logic [31:0] norm_pc(input logic [31:0] a);
        logic [31:0] r;
        r = a[25] ? (a | 32'hFC00_0000) : (a & 32'h03FF_FFFF);
        return r & 32'hFFFF_FFFE;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit is_irq, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.is_irq = is_irq; e.a = a; e.b = b;
        exq.push_back(e);
    endtask

    // ---------------- monitor ----------------
    bit          mon_en = 0, dir_mode = 0;
    bit          ir_pend = 0, prev_stall = 0, prev_wb = 0, prev_dec = 0;
    logic [31:0] ir_exp, prev_addr;
    int          last_fetch = -1, exec_run = 0, exp_exec_len = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ir_pend) begin
                chk("ir_o", ir_o, ir_exp);
                chk("decode_after_fetch", 32'(decode_en), 32'd1);
                ir_pend = 0;
            end
            if (prev_stall && imem_req)
                chk("imem_addr_stable", imem_addr, prev_addr);
            if (imem_req && imem_ack) begin
                if (exq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL fetch_unexpected: got fetch at %h expected none", imem_addr);
                end else begin
                    ev = exq.pop_front();
                    chk("fetch_kind", 32'(ev.is_irq), 32'd0);
                    chk("fetch_addr", imem_addr, ev.a);
                    chk("pc_o", pc_o, ev.a);
                end
                if (dir_mode && last_fetch >= 0)
                    chk("fetch_spacing", 32'(cyc - last_fetch), 32'd4);
                last_fetch = cyc;
                ir_pend = 1;
                ir_exp = imem_rdata;
            end
            prev_stall = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (irq_ack) begin
                if (exq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL irq_unexpected: got irq_ack eipc %h expected none", eipc_o);
                end else begin
                    ev = exq.pop_front();
                    chk("irq_kind", 32'(ev.is_irq), 32'd1);
                    chk("eipc_o", eipc_o, ev.a);
                    chk("eiic_o", eiic_o, ev.b);
                    chk("eipc_we", 32'(eipc_we), 32'd1);
                end
            end
            if (wb_en) chk("wb_pulse", 32'(prev_wb), 32'd0);
            prev_wb = wb_en;
            if (decode_en) chk("decode_pulse", 32'(prev_dec), 32'd0);
            prev_dec = decode_en;
            if (exec_en) exec_run++;
            else if (exec_run > 0) begin
                chk("exec_len", 32'(exec_run), 32'(exp_exec_len));
                exec_run = 0;
            end
        end
    end

    // ---------------- reactive environment / reference model ----------------
    bit          in_fetch = 0, in_exec = 0, halting = 0, halt_l = 0;
    bit          final_phase = 0, got_req = 0;
    int          ack_wait = 0, exec_wait = 0, halt_cnt = 0;
    logic [31:0] cur_pc, npc_l, halt_pc;

    task automatic drive_cycle();
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        exec_done  = 1'b0;
        halt_i     = 1'($urandom % 2);
        next_pc_i  = $urandom;
        imem_rdata = $urandom;
        if (dir_mode) begin
            irq_req = 1'b0; psw_id_i = 1'b0;
        end else begin
            irq_req = 1'($urandom % 2); psw_id_i = 1'($urandom % 2);
            if (!imem_req) imem_ack = 1'($urandom % 2);
            if (!exec_en)  exec_done = 1'($urandom % 2);
        end
        if (imem_req) begin
            if (final_phase) begin
                imem_ack = 1'b0; got_req = 1; mon_en = 0; rst = 1'b1;
            end else begin
                if (!in_fetch) begin
                    ack_wait = dir_mode ? 0 : $urandom_range(0, 4);
                    in_fetch = 1;
                end
                if (ack_wait == 0) begin
                    imem_ack = 1'b1; in_fetch = 0;
                end else ack_wait--;
            end
        end
        if (exec_en) begin
            if (!in_exec) begin
                exec_wait = dir_mode ? 0 : $urandom_range(0, 5);
                exp_exec_len = exec_wait + 1;
                in_exec = 1;
            end
            if (exec_wait == 0) begin
                exec_done = 1'b1; in_exec = 0;
                npc_l  = dir_mode ? cur_pc + 32'd4 : $urandom;
                halt_l = dir_mode ? 1'b0 : ($urandom % 6 == 0);
                next_pc_i = npc_l;
                halt_i = halt_l;
            end else exec_wait--;
        end
        if (wb_en) begin
            if (!dir_mode) begin
                irq_req = ($urandom % 3 == 0);
                psw_id_i = 1'($urandom % 2);
                if (irq_req && !psw_id_i) irq_code = 16'($urandom);
            end
            if (irq_req && !psw_id_i) begin
                push_ev(1, npc_l, {16'h0, irq_code});
                cur_pc = norm_pc(VEC);
                push_ev(0, cur_pc, 32'h0);
            end else if (halt_l) begin
                halting = 1;
                halt_cnt = $urandom_range(3, 22);
                halt_pc = norm_pc(npc_l);
            end else begin
                cur_pc = norm_pc(npc_l);
                push_ev(0, cur_pc, 32'h0);
            end
        end else if (halting) begin
            chk("halt_state", 32'(state_o), 32'd6);
            chk("halt_strobes", 32'({imem_req, decode_en, exec_en, wb_en, irq_ack, eipc_we}), 32'd0);
            if (halt_cnt == 0) begin
                irq_req = 1'b1; psw_id_i = 1'b0; irq_code = 16'($urandom);
                push_ev(1, halt_pc, {16'h0, irq_code});
                cur_pc = norm_pc(VEC);
                push_ev(0, cur_pc, 32'h0);
                halting = 0;
            end else begin
                psw_id_i = 1'b1;
                halt_cnt--;
            end
        end
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
        next_pc_i = 32'h0; halt_i = 1'b0; irq_req = 1'b0; irq_code = 16'h0; psw_id_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc_o", pc_o, RST_PC);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_strobes", 32'({imem_req, decode_en, exec_en, wb_en, irq_ack, eipc_we}), 32'd0);
        chk("rst_ir_o", ir_o, 32'h0);
        chk("rst_eipc_o", eipc_o, 32'h0);
        chk("rst_eiic_o", eiic_o, 32'h0);

        cur_pc = norm_pc(RST_PC);
        push_ev(0, cur_pc, 32'h0);
        mon_en = 1; dir_mode = 1;
        rst = 1'b0;
        repeat (26) drive_cycle();
        dir_mode = 0;
        repeat (3000) drive_cycle();

        final_phase = 1;
        for (int i = 0; i < 300 && !got_req; i++) drive_cycle();
        if (!got_req) begin
            n_cmp++; n_bad++;
            $display("FAIL final_fetch_timeout: got no fetch expected one within 300 cycles");
        end else begin
            chk("queue_left", 32'(exq.size()), 32'd1);
            @(posedge clk); #1;
            chk("midfetch_rst_req", 32'(imem_req), 32'd0);
            chk("midfetch_rst_pc", pc_o, RST_PC);
            chk("midfetch_rst_state", 32'(state_o), 32'd0);
            rst = 1'b0;
            @(posedge clk); #1;
            chk("post_rst_fetch", 32'({imem_req, state_o}), 32'({1'b1, 3'd1}));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
